reg_bank: RTL

Thirty-two-entry, 32-bit general-purpose register bank for the multicycle datapath. It receives the value chosen by the register write-data selection mux and returns operands to the A/B operand path. It has one write port and two read ports, and both read ports are registered. Register 29 resets to the stack-base constant 227 (32'd227).

---
 rtl/reg_bank.sv | 61 ++++++
 1 files changed

// File: rtl/reg_bank.sv
// Thirty-two-entry register bank: one write port, two registered read ports with write-to-read bypass.
// Register 0 reads as zero; register SP_INDEX resets to the stack-base constant.
module reg_bank #(
    parameter int                  DATA_W   = 32,
    parameter int                  ADDR_W   = 5,
    parameter int                  SP_INDEX = 29,
    parameter logic [DATA_W-1:0]   SP_RESET = 32'd227
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              reg_write,
    input  logic [ADDR_W-1:0] write_reg,
    input  logic [DATA_W-1:0] write_data,
    input  logic              read_en,
    input  logic [ADDR_W-1:0] read_reg_1,
    input  logic [ADDR_W-1:0] read_reg_2,
    output logic [DATA_W-1:0] read_data_1,
    output logic [DATA_W-1:0] read_data_2,
    output logic              read_valid
);

    localparam int DEPTH = 1 << ADDR_W;

    logic [DATA_W-1:0] regs [DEPTH];
    logic              wr_hit;
    logic [DATA_W-1:0] sel_1;
    logic [DATA_W-1:0] sel_2;

    assign wr_hit = reg_write && (write_reg != '0);

    // Read selectors: index 0 forces zero, a same-edge write to the index wins over stored data.
    always_comb begin
        sel_1 = regs[read_reg_1];
        sel_2 = regs[read_reg_2];
        if (wr_hit && (read_reg_1 == write_reg)) sel_1 = write_data;
        if (wr_hit && (read_reg_2 == write_reg)) sel_2 = write_data;
        if (read_reg_1 == '0) sel_1 = '0;
        if (read_reg_2 == '0) sel_2 = '0;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                regs[i] <= (i == SP_INDEX) ? SP_RESET : '0;
            end
            read_data_1 <= '0;
            read_data_2 <= '0;
            read_valid  <= 1'b0;
        end else begin
            if (wr_hit) begin
                regs[write_reg] <= write_data;
            end
            if (read_en) begin
                read_data_1 <= sel_1;
                read_data_2 <= sel_2;
            end
            read_valid <= read_en;
        end
    end

endmodule
